// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for pipe_hazard_ctrl
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - load-use compare between Execute load and Decode sources
module hazard_detect (
    input  logic [4:0] i_rs1_addrD,
    input  logic [4:0] i_rs2_addrD,
    input  logic [4:0] i_rd_addrE,
    input  logic       i_mem_rdE,
    output logic       o_load_use
);

    // x0 is hardwired to zero, so a load targeting it never produces a dependency
    assign o_load_use = i_mem_rdE && (i_rd_addrE != 5'd0) &&
                        ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; PIPE_CTRL_WATCHDOG_EN adds memory-wait watchdog
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_rs1_addrD,
    input  logic [4:0] i_rs2_addrD,
    input  logic [4:0] i_rd_addrE,
    input  logic       i_mem_rdE,
    input  logic       i_br_mispredE,
    input  logic       i_mem_reqM,
    input  logic       i_mem_readyM,
    output logic       o_StallF,
    output logic       o_StallD,
    output logic       o_StallE,
    output logic       o_StallM,
    output logic       o_StallW,
    output logic       o_FlushD,
    output logic       o_FlushE,
    output logic       o_FlushM,
    output logic       o_FlushW,
    output logic       o_busy,
    output logic       o_timeout_err
);

    ctrl_state_e state_q, state_d;
    logic        load_use;
    logic        mem_stall;
    logic        wd_expire;

    hazard_detect u_hazard_detect (
        .i_rs1_addrD (i_rs1_addrD),
        .i_rs2_addrD (i_rs2_addrD),
        .i_rd_addrE  (i_rd_addrE),
        .i_mem_rdE   (i_mem_rdE),
        .o_load_use  (load_use)
    );

    assign mem_stall = i_mem_reqM & ~i_mem_readyM;

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign wd_expire = (state_q == MEM_WAIT) && mem_stall && (cnt_q == CNT_MAX);

    // Held at zero in RUN so every MEM_WAIT entry starts counting from a clean slate
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | wd_expire;
        if (state_q == RUN) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_timeout_err = err_q;
`else
    assign wd_expire     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_stall) state_d = MEM_WAIT;
            MEM_WAIT: if (i_mem_readyM || wd_expire) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    assign o_busy = (state_q == MEM_WAIT);

    // Priority: watchdog abort, memory stall, mispredict, load-use
    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_StallW = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushM = 1'b0;
        o_FlushW = 1'b0;
        if (!i_rst) begin
            if (wd_expire) begin
                o_FlushM = 1'b1;
                o_FlushW = 1'b1;
            end else if (mem_stall) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_StallE = 1'b1;
                o_StallM = 1'b1;
                o_FlushW = 1'b1;
            end else if (i_br_mispredE) begin
                o_FlushD = 1'b1;
                o_FlushE = 1'b1;
            end else if (load_use) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_FlushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector, sequence and random checks for pipe_hazard_ctrl (PIPE_CTRL_WATCHDOG_EN aware)
module tb_pipe_hazard_ctrl;

    localparam int T = 4;
`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [4:0] rs1, rs2, rd;
    logic       memrd, mis, req, rdy;
    logic       StallF, StallD, StallE, StallM, StallW;
    logic       FlushD, FlushE, FlushM, FlushW;
    logic       busy, err;
    logic [10:0] got;

    int tests = 0;
    int fails = 0;
    bit m_busy, m_err;
    int m_cnt;
    int hit;

    always #5 i_clk = ~i_clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rs1_addrD   (rs1),
        .i_rs2_addrD   (rs2),
        .i_rd_addrE    (rd),
        .i_mem_rdE     (memrd),
        .i_br_mispredE (mis),
        .i_mem_reqM    (req),
        .i_mem_readyM  (rdy),
        .o_StallF      (StallF),
        .o_StallD      (StallD),
        .o_StallE      (StallE),
        .o_StallM      (StallM),
        .o_StallW      (StallW),
        .o_FlushD      (FlushD),
        .o_FlushE      (FlushE),
        .o_FlushM      (FlushM),
        .o_FlushW      (FlushW),
        .o_busy        (busy),
        .o_timeout_err (err)
    );

    assign got = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW, busy, err};

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       memrd, mis, req, rdy;
        logic [4:0] st;
        logic [3:0] fl;
        logic       busy;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic m,
                                logic p, logic q, logic y, logic [4:0] st, logic [3:0] fl, logic bz);
        vec_t v;
        v.rst = r; v.rs1 = a; v.rs2 = b; v.rd = d; v.memrd = m; v.mis = p;
        v.req = q; v.rdy = y; v.st = st; v.fl = fl; v.busy = bz;
        return v;
    endfunction

    task automatic check(string name, logic [10:0] g, logic [10:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, g, e);
        end
    endtask

    task automatic check_int(string name, int g, int e);
        tests++;
        if (g != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask

    task automatic drive(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic m,
                         logic p, logic q, logic y);
        i_rst = r; rs1 = a; rs2 = b; rd = d; memrd = m; mis = p; req = q; rdy = y;
    endtask

    function automatic bit m_load_use();
        return memrd && (rd != 0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic bit m_expire();
        return WD && m_busy && (m_cnt >= T) && req && !rdy;
    endfunction

    function automatic logic [10:0] model_out();
        logic [4:0] st = '0;
        logic [3:0] fl = '0;
        if (!i_rst) begin
            if (m_expire()) fl = 4'b0011;
            else if (req && !rdy) begin st = 5'b11110; fl = 4'b0001; end
            else if (mis) fl = 4'b1100;
            else if (m_load_use()) begin st = 5'b11000; fl = 4'b0100; end
        end
        return {st, fl, m_busy, m_err};
    endfunction

    task automatic model_step();
        if (i_rst) begin
            m_busy = 0; m_cnt = 0; m_err = 0;
        end else if (!m_busy) begin
            if (req && !rdy) begin m_busy = 1; m_cnt = 0; end
        end else if (rdy) begin
            m_busy = 0;
        end else if (m_expire()) begin
            m_busy = 0; m_err = 1;
        end else if (m_cnt < T) begin
            m_cnt++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vt[0]  = mk(1, 5, 0, 5, 1, 1, 1, 0, 5'b00000, 4'b0000, 0);
        vt[1]  = mk(0, 5, 0, 5, 1, 0, 0, 0, 5'b11000, 4'b0100, 0);
        vt[2]  = mk(0, 5, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0);
        vt[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 4'b0000, 0);
        vt[4]  = mk(0, 3, 7, 7, 1, 0, 0, 0, 5'b11000, 4'b0100, 0);
        vt[5]  = mk(0, 7, 0, 7, 1, 1, 0, 0, 5'b00000, 4'b1100, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 4'b1100, 0);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 4'b0001, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 4'b0001, 1);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 4'b0001, 1);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b00000, 4'b0000, 1);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0);
        vt[12] = mk(0, 6, 0, 6, 1, 1, 1, 0, 5'b11110, 4'b0001, 0);
        vt[13] = mk(1, 6, 0, 6, 1, 1, 1, 0, 5'b00000, 4'b0000, 1);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0);
        vt[15] = mk(0, 9, 0, 9, 0, 0, 0, 0, 5'b00000, 4'b0000, 0);
        vt[16] = mk(0, 4, 0, 4, 1, 0, 1, 0, 5'b11110, 4'b0001, 0);
        vt[17] = mk(0, 4, 0, 4, 1, 0, 1, 1, 5'b11000, 4'b0100, 1);
        vt[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        m_busy = 0; m_err = 0; m_cnt = 0;
        tick();
        tick();
        #2 check("reset_state", got, 11'b0);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].rst, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].memrd, vt[i].mis, vt[i].req, vt[i].rdy);
            #2 check($sformatf("vec%0d", i), got, {vt[i].st, vt[i].fl, vt[i].busy, 1'b0});
            tick();
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
`ifdef PIPE_CTRL_WATCHDOG_EN
        hit = -1;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 20; c++) begin
            #2;
            if (FlushM && FlushW && !StallF) begin
                hit = c;
                break;
            end
            tick();
        end
        check_int("wd_expiry_cycle", hit, T + 1);
        check("wd_expiry_outputs", got, {5'b00000, 4'b0011, 1'b1, 1'b0});
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 check("wd_err_set", got, {9'b0, 1'b0, 1'b1});
        tick(); tick(); tick();
        #2 check("wd_err_sticky", got, {9'b0, 1'b0, 1'b1});
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 check("wd_err_cleared", got, 11'b0);
        tick();
`else
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 10; c++) begin
            #2;
            if (c == 5 || c == 9) check($sformatf("long_wait%0d", c), got, {5'b11110, 4'b0001, 1'b1, 1'b0});
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        #2 check("long_wait_release", got, {9'b0, 1'b1, 1'b0});
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 check("long_wait_idle", got, 11'b0);
        tick();
`endif

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4));
            #2 check($sformatf("rand%0d", n), got, model_out());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 64, memory-wait cycles before watchdog abort (range 2..1024).
REQ-002 SHALL have port: i_clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: i_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: i_rs1_addrD, i_rs2_addrD  in  5 each  source registers of instruction in Decode.
REQ-005 SHALL have ports: i_rd_addrE  in  5  destination of instruction in Execute; i_mem_rdE  in  1  Execute instruction is a load.
REQ-006 SHALL have port: i_br_mispredE  in  1  branch/jump redirect resolved in Execute.
REQ-007 SHALL have ports: i_mem_reqM  in  1  Memory-stage access active; i_mem_readyM  in  1  data memory completes access this cycle.
REQ-008 SHALL have ports: o_StallF, o_StallD, o_StallE, o_StallM, o_StallW  out  1 each  hold stage register.
REQ-009 SHALL have ports: o_FlushD, o_FlushE, o_FlushM, o_FlushW  out  1 each  load bubble into stage register.
REQ-010 SHALL have ports: o_busy  out  1  registered, FSM in MEM_WAIT; o_timeout_err  out  1  sticky watchdog flag.

Function
REQ-011 SHALL implement FSM states RUN and MEM_WAIT.
REQ-012 RUN -> MEM_WAIT SHALL occur when i_mem_reqM=1 and i_mem_readyM=0; MEM_WAIT -> RUN on i_mem_readyM=1 or watchdog expiry.
REQ-013 mem_stall = i_mem_reqM & ~i_mem_readyM SHALL be combinational, effective in the same cycle regardless of state.
REQ-014 During mem_stall: StallF/D/E/M=1, StallW=0, FlushW=1 (bubble prevents double writeback); all other flushes 0.
REQ-015 Load-use SHALL be detected when i_mem_rdE=1, i_rd_addrE!=0 and i_rd_addrE equals i_rs1_addrD or i_rs2_addrD.
REQ-016 Load-use (no mem_stall) SHALL assert StallF=1, StallD=1, FlushE=1 for exactly one cycle; the bubble clears the condition.
REQ-017 Mispredict (no mem_stall) SHALL assert FlushD=1 and FlushE=1 in the same cycle; StallF=StallD=0.
REQ-018 Mispredict and load-use together: mispredict wins; FlushD=FlushE=1, no stall.
REQ-019 Mispredict or load-use coinciding with mem_stall SHALL be ignored that cycle; Execute is held, so the event is re-evaluated on the release cycle.
REQ-020 Register x0 SHALL never create a hazard.
REQ-021 Wait counter SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle, saturate, never wrap.
REQ-022 o_busy SHALL equal 1 exactly while the FSM state is MEM_WAIT.
REQ-023 Unused flush/stall outputs SHALL be 0 in RUN with no hazard.

Reset
REQ-024 On i_rst=1 at a clock edge: state=RUN, counter=0, o_busy=0, o_timeout_err=0.
REQ-025 While i_rst=1, all Stall* and Flush* outputs SHALL be 0 regardless of inputs.
REQ-026 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no timeout flagged.

Configuration
REQ-027 Macro PIPE_CTRL_WATCHDOG_EN defined: on counter reaching TIMEOUT_CYCLES in MEM_WAIT, that cycle SHALL force FlushM=1, FlushW=1, no stalls, set o_timeout_err=1 (sticky until reset), return to RUN.
REQ-028 Macro undefined: no counter, o_timeout_err tied 0, MEM_WAIT exits only on i_mem_readyM.

Structure
REQ-029 Shared package pipe_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT) and the TIMEOUT_CYCLES default constant.
REQ-030 Combinational load-use/x0 compare SHALL be sub-module hazard_detect; FSM, counter and output priority stay in pipe_hazard_ctrl.

Verification
REQ-031 Load x5 in E, rs1D=5 -> one cycle StallF=StallD=FlushE=1, next cycle all 0.
REQ-032 Load x0 in E, rs2D=0 -> no stall, no flush.
REQ-033 mem_reqM=1, ready low 3 cycles -> StallF..M=1, FlushW=1 for 3 cycles, o_busy=1 cycles 2-4, ready=1 releases the same cycle.
REQ-034 Mispredict and load-use asserted together -> FlushD=FlushE=1, StallF=StallD=0.
REQ-035 WATCHDOG_EN, TIMEOUT_CYCLES=4, ready never asserted -> FlushM=FlushW=1 on expiry cycle, o_timeout_err=1 until i_rst.
REQ-036 i_rst=1 during MEM_WAIT -> next cycle o_busy=0, state RUN, o_timeout_err=0.
